uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer for the UART peripheral, placed between the bit-level receiver and the CSR block. It captures each byte strobed out by the receiver and presents the oldest byte to the CSR `RECEIVED_DATA` field. It pops on the CSR read trigger and drives the UART interrupt from its fill level. This decouples firmware read latency from line rate, so back-to-back frames at 115200 baud are no longer lost.

## Interface
Parameters:
- `DEPTH`, 16: entries; power of two, 2..256.
- `DATA_W`, 8: byte width.
- `CNT_W`, $clog2(DEPTH)+1: width of level and threshold.

Ports:
- `wb_clk_i` in 1: single clock; all logic rising-edge.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `in_valid` in 1: one-cycle strobe from the receiver; a byte is complete.
- `in_data` in DATA_W: received byte, valid with `in_valid`.
- `read` in 1: pop strobe, driven by the CSR `RECEIVED_DATA` read trigger.
- `irq_en` in 1: interrupt enable from CSR.
- `irq_thresh` in CNT_W: interrupt fill threshold (used only with the macro).
- `overrun_clr` in 1: clears the sticky overrun flag.
- `rd_data` out DATA_W: head byte; 0 when empty.
- `level` out CNT_W: current occupancy, 0..DEPTH.
- `empty` out 1: level == 0.
- `full` out 1: level == DEPTH.
- `overrun` out 1: sticky; a byte was dropped.
- `irq` out 1: registered interrupt request.

## Operation
- Storage: DEPTH-entry circular array, with `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits each; both wrap modulo DEPTH. `level` is a separate registered counter.
- Push: `in_valid` and not full → write `mem[wr_ptr]`, `wr_ptr`+1, `level`+1.
- Pop: `read` and not empty → `rd_ptr`+1, `level`-1. A pop while empty is ignored; no pointer or level change.
- Push and pop in the same cycle:
  - Neither empty nor full: both happen, `level` unchanged.
  - Full: the pop frees a slot and the push is accepted, with no overrun.
  - Empty: the pop is ignored and the push is accepted, `level`=1.
- Overrun: `in_valid` while full with no pop → byte dropped, storage untouched, `overrun` set. `overrun_clr` clears it. If set and clear coincide, set wins.
- `rd_data` = `mem[rd_ptr]` when `level`≠0, else 0. Combinational from registers (first-word fall-through).
- No state machine beyond pointers, counter and flags. Reset mid-operation discards all contents.

## Timing
- All outputs reset to 0 on the first rising edge with `wb_rst_i`=1: `level`=0, `empty`=1, `full`=0, `overrun`=0, `irq`=0, `rd_data`=0.
- Push at edge N → `rd_data`, `level`, `empty` updated after edge N (visible in cycle N+1).
- Pop at edge N → the next byte appears on `rd_data` in cycle N+1. Back-to-back pops every cycle are supported.
- `irq` is registered: it reflects the condition computed from the post-update `level` one edge later, i.e. 2 edges after the causing push.
- `irq` deasserts one edge after `level` drops below the condition or `irq_en` falls.

## Configuration
- `UART_RX_FIFO_THRESH_IRQ_EN` defined: `irq` = `irq_en` & (`level` >= max(`irq_thresh`,1)). A threshold above DEPTH never fires. `irq_thresh` is used.
- Not defined: `irq` = `irq_en` & ~`empty`. `irq_thresh` is left unconnected internally; the port remains for uniform instantiation.

## Structure
- The shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8
  - `UART_RX_FIFO_DEPTH` = 16
  - the `uart_byte_t` typedef
- One sub-module: `uart_fifo_mem`, a simple dual-port register array with write-enable and asynchronous read. The pointer, level, flag and irq logic stays in `uart_rx_fifo`.
- The top-level `uart` instantiates `uart_rx_fifo` between `uart_receive` (`rx_data`/valid strobe) and CSR (`RECEIVED_DATA`, read trigger).

## Test plan
- Reset, then push 0x41, 0x42, 0x43 → `level`=3 and `rd_data`=0x41. Three pops return 0x41, 0x42, 0x43, then `empty`=1 and `rd_data`=0.
- Fill 16 bytes 0x00..0x0F, push 0xAA → `full`=1, `overrun`=1, contents unchanged. 16 pops return 0x00..0x0F. `overrun_clr` → 0.
- Full, with push 0x55 and pop in the same cycle → `overrun`=0 and `level` stays 16. After 16 more pops the last byte read is 0x55.
- Empty, with pop and push 0x77 in the same cycle → `level`=1 and `rd_data`=0x77.
- With the macro, `irq_thresh`=4 and `irq_en`=1: pushes 1..3 → `irq`=0. The 4th push → `irq`=1 two edges later, and one pop → `irq`=0. Without the macro, the first push → `irq`=1.
- Push 5 bytes, assert `wb_rst_i` for 1 cycle → `level`=0, `empty`=1, `irq`=0. A following push 0x99 → `rd_data`=0x99.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width, RX FIFO depth and the byte type.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write with enable, asynchronous read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with first-word fall-through, sticky overrun and level-driven irq.
// Define UART_RX_FIFO_THRESH_IRQ_EN to raise irq on a fill threshold instead of non-empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              read,
    input  logic              irq_en,
    input  logic [CNT_W-1:0]  irq_thresh,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              irq
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] head;
    logic              do_push;
    logic              do_pop;
    logic              irq_cond;

    assign empty   = (level == '0);
    assign full    = (level == CNT_W'(DEPTH));
    assign do_pop  = read & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign do_push = in_valid & (~full | do_pop);

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk   (wb_clk_i),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign rd_data = empty ? '0 : head;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            overrun <= 1'b0;
        end else if (in_valid && !do_push) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic [CNT_W-1:0] thresh_eff;
    assign thresh_eff = (irq_thresh == '0) ? CNT_W'(1) : irq_thresh;
    assign irq_cond   = irq_en & (level >= thresh_eff);
`else
    logic unused_thresh;
    assign unused_thresh = ^irq_thresh;
    assign irq_cond      = irq_en & ~empty;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_cond;
        end
    end

endmodule
